// File: rtl/datapath_pkg.sv
// Shared types for the pipelined register-file + ALU datapath: ALU opcodes and flag bundle.
package datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_PASSB = 3'b110,
    ALU_NOR   = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } flags_t;

  localparam int     ALU_OPS   = 8;
  localparam flags_t FLAGS_RST = '{zero: 1'b1, carry: 1'b0, overflow: 1'b0};

  // Only ADD/SUB drive carry and overflow; every other op reports them as 0.
  function automatic logic is_arith(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/datapath_regfile.sv
// NREGS x WIDTH register file: two async read ports, one debug read port, one sync write port.
module datapath_regfile
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic [WIDTH-1:0] dbg_data
);

  logic [NREGS-1:0][WIDTH-1:0] regs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    regs        <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage (EX -> WB) register-file + ALU datapath with valid/ready issue.
// PIPELINED_DATAPATH_BYPASS_EN selects EX/WB forwarding; otherwise RAW hazards stall one cycle.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             wr,
  input  logic [2:0]       alu_ctrl,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [AW-1:0]    addr3,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr3;
  } exwb_t;

  exwb_t            exwb;
  logic             vld_pipe;
  logic             run_q;
  logic [WIDTH-1:0] res_q;
  flags_t           flg_q;

  logic [WIDTH-1:0] rd1, rd2, opa, opb, bx, alu_res;
  logic [WIDTH:0]   sum;
  flags_t           alu_flg;
  alu_op_e          op;
  logic             sub, hit1, hit2, hazard, accept;

  datapath_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (vld_pipe && exwb.wr),
    .waddr    (exwb.addr3),
    .wdata    (res_q),
    .raddr1   (addr1),
    .raddr2   (addr2),
    .dbg_addr (dbg_addr),
    .rdata1   (rd1),
    .rdata2   (rd2),
    .dbg_data (dbg_data)
  );

  // A source matches the op sitting in WB whose write has not landed yet.
  assign hit1 = vld_pipe && exwb.wr && (exwb.addr3 == addr1);
  assign hit2 = vld_pipe && exwb.wr && !use_imm && (exwb.addr3 == addr2);

`ifdef PIPELINED_DATAPATH_BYPASS_EN
  assign hazard = 1'b0;
  assign opa    = hit1 ? res_q : rd1;
  assign opb    = use_imm ? imm : (hit2 ? res_q : rd2);
`else
  assign hazard = hit1 || hit2;
  assign opa    = rd1;
  assign opb    = use_imm ? imm : rd2;
`endif

  assign in_ready = run_q && !hazard;
  assign accept   = in_valid && in_ready;

  // SUB is A + ~B + 1 so carry-out reads directly as "no borrow".
  assign op  = alu_op_e'(alu_ctrl);
  assign sub = (op == ALU_SUB);
  assign bx  = sub ? ~opb : opb;
  assign sum = {1'b0, opa} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD,
      ALU_SUB:   alu_res = sum[WIDTH-1:0];
      ALU_AND:   alu_res = opa & opb;
      ALU_OR:    alu_res = opa | opb;
      ALU_XOR:   alu_res = opa ^ opb;
      ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      ALU_PASSB: alu_res = opb;
      ALU_NOR:   alu_res = ~(opa | opb);
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    alu_flg          = '{zero: 1'b0, carry: 1'b0, overflow: 1'b0};
    alu_flg.zero     = (alu_res == '0);
    if (is_arith(op)) begin
      alu_flg.carry    = sum[WIDTH];
      alu_flg.overflow = (opa[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
    end
  end

  // Result/flags only move on an accepted op; an idle cycle just drops the valid bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      vld_pipe <= 1'b0;
      exwb     <= '0;
      res_q    <= '0;
      flg_q    <= FLAGS_RST;
    end else begin
      run_q    <= 1'b1;
      vld_pipe <= accept;
      if (accept) begin
        exwb.wr    <= wr;
        exwb.addr3 <= addr3;
        res_q      <= alu_res;
        flg_q      <= alu_flg;
      end
    end
  end

  assign out_valid = vld_pipe;
  assign result    = res_q;
  assign zero      = flg_q.zero;
  assign carry     = flg_q.carry;
  assign overflow  = flg_q.overflow;

endmodule
